// File: rtl/project1.sv
// Four-digit multiplexed 7-segment driver: scans s3..s0 onto one shared segment
// bus with one digit enable active per slot; every output comes straight from a flop.
module project1 #(
    parameter int REFRESH_DIV    = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [3:0] s3,
    input  logic [3:0] s2,
    input  logic [3:0] s1,
    input  logic [3:0] s0,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       A4
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    scan_q, scan_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          tick;
    logic [3:0]    nibble;
    logic [6:0]    pattern;
    logic [3:0]    an_hot;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        p = 7'h00;
        case (v)
            4'h0: p = 7'h7E;
            4'h1: p = 7'h30;
            4'h2: p = 7'h6D;
            4'h3: p = 7'h79;
            4'h4: p = 7'h33;
            4'h5: p = 7'h5B;
            4'h6: p = 7'h5F;
            4'h7: p = 7'h70;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h7B;
            4'hA: p = 7'h77;
            4'hB: p = 7'h1F;
            4'hC: p = 7'h4E;
            4'hD: p = 7'h3D;
            4'hE: p = 7'h4F;
            default: p = 7'h47;
        endcase
        return p;
    endfunction

    assign tick = (div_q == DIV_LAST);

    // Next slot is computed from the advanced index so the new digit and its
    // nibble land in the output flops on the same edge.
    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        scan_d  = scan_q + 2'd1;
        nibble  = s3;
        an_hot  = 4'b1000;
        case (scan_d)
            2'd0: begin nibble = s3; an_hot = 4'b1000; end
            2'd1: begin nibble = s2; an_hot = 4'b0100; end
            2'd2: begin nibble = s1; an_hot = 4'b0010; end
            default: begin nibble = s0; an_hot = 4'b0001; end
        endcase
        pattern = decode(nibble);
        seg_d   = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;
        an_d    = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            div_q  <= '0;
            scan_q <= 2'd3;
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
        end else begin
            div_q <= div_d;
            if (tick) begin
                scan_q <= scan_d;
                seg_q  <= seg_d;
                an_q   <= an_d;
            end
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign {A1, A2, A3, A4}      = an_q;

endmodule

// File: tb/tb_project1.sv
// Directed bench for the 7-segment scanner: default instance plus a REFRESH_DIV=4
// instance sharing clock, reset and nibbles.
module tb_project1;

    logic       clk;
    logic       clrn;
    logic [3:0] s3, s2, s1, s0;
    logic       a, b, c, d, e, f, g, A1, A2, A3, A4;
    logic       a4, b4, c4, d4, e4, f4, g4, A1_4, A2_4, A3_4, A4_4;

    int n_vec = 0;
    int n_bad = 0;

    // Active-low segment codes (abcdefg) for hex digits 0..F.
    logic [6:0] seg_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [3:0] an_tbl [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    wire [6:0] seg  = {a, b, c, d, e, f, g};
    wire [3:0] an   = {A1, A2, A3, A4};
    wire [6:0] seg4 = {a4, b4, c4, d4, e4, f4, g4};
    wire [3:0] an4  = {A1_4, A2_4, A3_4, A4_4};

    project1 u_dut (
        .clk(clk), .clrn(clrn), .s3(s3), .s2(s2), .s1(s1), .s0(s0),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .A1(A1), .A2(A2), .A3(A3), .A4(A4)
    );

    project1 #(.REFRESH_DIV(4)) u_div4 (
        .clk(clk), .clrn(clrn), .s3(s3), .s2(s2), .s1(s1), .s0(s0),
        .a(a4), .b(b4), .c(c4), .d(d4), .e(e4), .f(f4), .g(g4),
        .A1(A1_4), .A2(A2_4), .A3(A3_4), .A4(A4_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_one_cold(input string tag);
        check(tag, 32'($countones(an)), 32'd3);
    endtask

    initial begin
        clrn = 1'b0;
        {s3, s2, s1, s0} = 16'h0000;
        @(negedge clk);

        // Reset blanks everything
        step();
        check("rst_an", 32'(an), 32'b1111);
        check("rst_seg", 32'(seg), 32'b1111111);

        // Scan 0,1,2,3
        clrn = 1'b1;
        {s3, s2, s1, s0} = 16'h0123;
        step(); check("t2_an_A1", 32'(an), 32'b0111); check("t2_seg_A1", 32'(seg), 32'b0000001);
        step(); check("t2_an_A2", 32'(an), 32'b1011); check("t2_seg_A2", 32'(seg), 32'b1001111);
        step(); check("t2_an_A3", 32'(an), 32'b1101); check("t2_seg_A3", 32'(seg), 32'b0010010);
        step(); check("t2_an_A4", 32'(an), 32'b1110); check("t2_seg_A4", 32'(seg), 32'b0000110);
        step(); check("t2_an_wrap", 32'(an), 32'b0111); check("t2_seg_wrap", 32'(seg), 32'b0000001);

        // Switch to 9,8,7,6 mid-scan (A1 currently shown)
        {s3, s2, s1, s0} = 16'h9876;
        step(); check("t3_an_A2", 32'(an), 32'b1011); check("t3_seg_A2", 32'(seg), 32'b0000000);
        check_one_cold("t3_onecold");
        step(); check("t3_an_A3", 32'(an), 32'b1101); check("t3_seg_A3", 32'(seg), 32'b0001111);
        check_one_cold("t3_onecold");
        step(); check("t3_an_A4", 32'(an), 32'b1110); check("t3_seg_A4", 32'(seg), 32'b0100000);
        check_one_cold("t3_onecold");
        step(); check("t3_an_A1", 32'(an), 32'b0111); check("t3_seg_A1", 32'(seg), 32'b0000100);
        check_one_cold("t3_onecold");

        // Sweep s3 through 0..F, observing each value in the A1 slot
        for (int v = 0; v < 16; v++) begin
            s3 = 4'(v);
            for (int k = 0; k < 4; k++) begin
                step();
                check_one_cold("t4_onecold");
            end
            check("t4_an", 32'(an), 32'b0111);
            check($sformatf("t4_seg_%0h", v), 32'(seg), 32'(seg_tbl[v]));
        end

        // Reset while A3 is active
        step(); step();
        check("t6_an_A3", 32'(an), 32'b1101);
        clrn = 1'b0;
        step();
        check("t6_rst_an", 32'(an), 32'b1111);
        check("t6_rst_seg", 32'(seg), 32'b1111111);
        clrn = 1'b1;
        step();
        check("t6_an_A1", 32'(an), 32'b0111);
        check("t6_seg_A1", 32'(seg), 32'b0111000);

        // REFRESH_DIV=4: blank 3 edges after release, then 4 edges per digit
        {s3, s2, s1, s0} = 16'h1234;
        clrn = 1'b0;
        step();
        check("t5_rst_an", 32'(an4), 32'b1111);
        clrn = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n < 4) begin
                check("t5_blank_an", 32'(an4), 32'b1111);
                check("t5_blank_seg", 32'(seg4), 32'b1111111);
            end else begin
                check($sformatf("t5_an_e%0d", n), 32'(an4), 32'(an_tbl[((n - 4) / 4) % 4]));
                check($sformatf("t5_seg_e%0d", n), 32'(seg4),
                      32'(seg_tbl[((n - 4) / 4) % 4 + 1]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
